// File: rtl/mult_div_seq.sv
// Multicycle MULT/DIV sequencer owning the HI/LO registers.
// Signed radix-2 Booth multiply and signed restoring divide, one step per clock.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        StIdle,
        StMult,
        StDiv,
        StFix,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             last_step;

    // Booth datapath: {A, Q, q-1}; A is kept one bit wider during the add so
    // that the most negative multiplicand cannot overflow before the shift.
    logic [WIDTH-1:0] mcand_q;
    logic [2*WIDTH:0] prod_q, prod_step;
    logic [WIDTH:0]   a_ext, m_ext, booth_sum;

    // Restoring divider on magnitudes; quo_q shifts the dividend out as the
    // quotient bits shift in.
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff, rem_step, quo_step;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             neg_q, neg_r, dz_q;

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign abs_a     = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b     = src_b[WIDTH-1] ? -src_b : src_b;

    // One Booth step: add/sub on the upper half, then arithmetic shift right.
    always_comb begin
        a_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
        m_ext = {mcand_q[WIDTH-1], mcand_q};
        case (prod_q[1:0])
            2'b01:   booth_sum = a_ext + m_ext;
            2'b10:   booth_sum = a_ext - m_ext;
            default: booth_sum = a_ext;
        endcase
        prod_step = {booth_sum, prod_q[WIDTH:1]};
    end

    // One restoring-division step producing one quotient bit.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift[WIDTH-1:0] - dvs_q;
        if (rem_shift >= {1'b0, dvs_q}) begin
            rem_step = rem_diff;
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (!op) begin
                        state_d = StMult;
                    end else if (src_b == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StMult: begin
                busy = 1'b1;
                if (last_step) state_d = StDone;
            end
            StDiv: begin
                busy = 1'b1;
                if (last_step) state_d = StFix;
            end
            StFix: begin
                busy    = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done     = 1'b1;
                div_zero = dz_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO update.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    dz_q  <= 1'b0;
                    if (start) begin
                        if (!op) begin
                            mcand_q <= src_a;
                            prod_q  <= {{WIDTH{1'b0}}, src_b, 1'b0};
                        end else if (src_b == '0) begin
                            dz_q <= 1'b1;
                        end else begin
                            rem_q <= '0;
                            quo_q <= abs_a;
                            dvs_q <= abs_b;
                            neg_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                            neg_r <= src_a[WIDTH-1];
                        end
                    end
                end
                StMult: begin
                    prod_q <= prod_step;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        hi <= prod_step[2*WIDTH:WIDTH+1];
                        lo <= prod_step[WIDTH:1];
                    end
                end
                StDiv: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                StFix: begin
                    // Quotient truncates toward zero; remainder follows the dividend.
                    lo <= neg_q ? -quo_q : quo_q;
                    hi <= neg_r ? -rem_q : rem_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: cycle-level behavioural model plus pinned literal results.
module tb_mult_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Behavioural model: countdown to done, result computed with 64-bit arithmetic.
    logic               m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic        [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic               p_dz = 1'b0, was_done;
    logic signed [63:0] pa, pb, pr, pq;
    int                 remaining = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_hi = '0; m_lo = '0; remaining = 0;
        end else begin
            was_done = m_done;
            m_done = 1'b0;
            m_dz = 1'b0;
            if (remaining > 0) begin
                remaining = remaining - 1;
                if (remaining == 0) begin
                    m_done = 1'b1; m_dz = p_dz; m_hi = p_hi; m_lo = p_lo;
                end
            end else if (start && !was_done) begin
                pa = {{32{src_a[31]}}, src_a};
                pb = {{32{src_b[31]}}, src_b};
                if (!op) begin
                    pr = pa * pb;
                    p_hi = pr[63:32]; p_lo = pr[31:0]; p_dz = 1'b0;
                    remaining = 32;
                end else if (src_b == 32'h0) begin
                    m_done = 1'b1; m_dz = 1'b1;
                end else begin
                    pq = pa / pb;
                    pr = pa % pb;
                    p_lo = pq[31:0]; p_hi = pr[31:0]; p_dz = 1'b0;
                    remaining = 33;
                end
            end
            m_busy = (remaining > 0);
        end
    end

    // Hand-computed expectations, keyed by absolute cycle number.
    typedef struct {
        int          at;
        logic        busy;
        logic        done;
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } pin_t;
    pin_t pins[32];
    int   pin_n = 0;
    int   tmo_count = 0;
    int   tmo_seen = 0;
    bit   end_req = 1'b0;

    int checks = 0;
    int errors = 0;

    // Single compare process: model every cycle, pins when due, then summary.
    always @(negedge clk) begin
        checks++;
        if ({busy, done, div_zero, hi, lo} !== {m_busy, m_done, m_dz, m_hi, m_lo}) begin
            errors++;
            $display("FAIL model cyc %0d busy/done/dz/hi/lo got %b %b %b %h %h want %b %b %b %h %h",
                     cyc, busy, done, div_zero, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
        end
        for (int i = 0; i < pin_n; i++) begin
            if (pins[i].at == cyc) begin
                checks++;
                if ({busy, done, div_zero, hi, lo} !==
                    {pins[i].busy, pins[i].done, pins[i].dz, pins[i].hi, pins[i].lo}) begin
                    errors++;
                    $display("FAIL pin%0d cyc %0d busy/done/dz/hi/lo got %b %b %b %h %h want %b %b %b %h %h",
                             i, cyc, busy, done, div_zero, hi, lo, pins[i].busy, pins[i].done,
                             pins[i].dz, pins[i].hi, pins[i].lo);
                end
            end
        end
        if (tmo_count != tmo_seen) begin
            checks++;
            errors++;
            tmo_seen++;
        end
        if (end_req) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        if (cyc > 20000) begin
            $display("FAIL watchdog cyc %0d got no end want end", cyc);
            $fatal(1);
        end
    end

    task automatic add_pin(input int at, input logic b, input logic d, input logic z,
                           input logic [31:0] h, input logic [31:0] l);
        if (pin_n < 32) begin
            pins[pin_n] = '{at: at, busy: b, done: d, dz: z, hi: h, lo: l};
            pin_n++;
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3: begin
                v = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one operation; returns at the negedge of its done cycle (or after
    // the abort window when a reset is injected).
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input bit pin, input logic [31:0] ehi, input logic [31:0] elo,
                          input int poke_at, input int rst_at, input bit noise,
                          input bit start_in_done);
        int c0;
        int lat;
        int rel;
        @(negedge clk);
        c0 = cyc;
        start = 1'b1; op = o; src_a = a; src_b = b;
        lat = o ? ((b == 32'h0) ? 1 : 34) : 33;
        if (pin) add_pin(c0 + lat, 1'b0, 1'b1, o && (b == 32'h0), ehi, elo);
        if (rst_at > 0) begin
            add_pin(c0 + rst_at + 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            add_pin(c0 + 33, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        @(negedge clk);
        rel = 1;
        start = 1'b0;
        while (1) begin
            if (done) break;
            if (rst_at == 0 && rel >= 60) begin
                $display("FAIL timeout op %0d got no done want done", o);
                tmo_count++;
                break;
            end
            if (rst_at != 0 && rel >= 45) break;
            reset = (rel == rst_at);
            start = (rel == poke_at) || (noise && ($urandom_range(0, 7) == 0));
            op = 1'($urandom_range(0, 1));
            src_a = $urandom;
            src_b = $urandom;
            @(negedge clk);
            rel++;
        end
        reset = 1'b0;
        start = start_in_done;
        op = 1'($urandom_range(0, 1));
        src_a = $urandom;
        src_b = $urandom;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, issued back to back.
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 1'b0, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, 0, 0, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h1, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 32'h0000_0451, 32'h20, 1'b1, 32'h11, 32'h22, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 32'd5, 32'h0, 1'b1, 32'h11, 32'h22, 0, 0, 1'b0, 1'b1);

        // A start in the DONE cycle above must be ignored; second start mid-run too.
        run_op(1'b0, 32'd3, 32'hFFFF_FFFB, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 10, 0, 1'b0, 1'b0);

        // Reset at cycle 20 aborts the operation and clears HI/LO.
        run_op(1'b0, 32'h1234, 32'h10, 1'b0, 32'h0, 32'h0, 0, 20, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;

        // Randomized operations with spurious starts while busy and random gaps.
        for (int n = 0; n < 40; n++) begin
            run_op(1'($urandom_range(0, 1)), pick(), pick(), 1'b0, 32'h0, 32'h0, 0, 0, 1'b1,
                   1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(negedge clk);
                start = 1'b0;
            end
        end

        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        end_req = 1'b1;
    end

endmodule
